// File: rtl/flexbex_efpga_responder.sv
// Fabric-side responder for the core<->eFPGA custom-instruction interface.
// It launches a fabric computation and completes it with either a fixed latency or a valid handshake with timeout.
module flexbex_efpga_responder #(
  parameter int unsigned TIMEOUT    = 64,
  parameter logic [31:0] ERR_RESULT = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        write_strobe_i,
  input  logic [1:0]  operator_i,
  input  logic [31:0] operand_a_i,
  input  logic [31:0] operand_b_i,
  input  logic [3:0]  delay_i,
  output logic [31:0] result_a_o,
  output logic [31:0] result_b_o,
  output logic [31:0] result_c_o,
  output logic        fpga_done_o,
  output logic        fabric_start_o,
  output logic [1:0]  fabric_operator_o,
  output logic [31:0] fabric_op_a_o,
  output logic [31:0] fabric_op_b_o,
  input  logic [31:0] fabric_result_a_i,
  input  logic [31:0] fabric_result_b_i,
  input  logic [31:0] fabric_result_c_i,
  input  logic        fabric_valid_i,
  output logic        timeout_o,
  output logic        overrun_o,
  input  logic        clear_err_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t      state_r;
  logic [7:0]  count_r;
  logic [3:0]  delay_r;

  logic        accept_s;
  logic        overrun_set_s;
  logic        capture_s;
  logic        expire_s;

  // Decode request acceptance and completion events for the current cycle.
  always_comb begin
    accept_s      = 1'b0;
    overrun_set_s = 1'b0;
    capture_s     = 1'b0;
    expire_s      = 1'b0;
    if (state_r == RUN) begin
      overrun_set_s = write_strobe_i;
      if (delay_r != 4'd0) begin
        // The counter reads 1 on edge E0+D, since it was loaded with D at E0.
        capture_s = (count_r == 8'd1);
      end else begin
        capture_s = fabric_valid_i;
        expire_s  = !fabric_valid_i && (count_r == 8'd1);
      end
    end else begin
      accept_s = write_strobe_i;
    end
  end

  // Control FSM with registered outputs and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r           <= IDLE;
      count_r           <= 8'd0;
      delay_r           <= 4'd0;
      result_a_o        <= 32'd0;
      result_b_o        <= 32'd0;
      result_c_o        <= 32'd0;
      fpga_done_o       <= 1'b0;
      fabric_start_o    <= 1'b0;
      fabric_operator_o <= 2'd0;
      fabric_op_a_o     <= 32'd0;
      fabric_op_b_o     <= 32'd0;
      timeout_o         <= 1'b0;
      overrun_o         <= 1'b0;
    end else begin
      fabric_start_o <= 1'b0;
      timeout_o      <= expire_s | (timeout_o & ~clear_err_i);
      overrun_o      <= overrun_set_s | (overrun_o & ~clear_err_i);
      case (state_r)
        IDLE, DONE: begin
          if (accept_s) begin
            fabric_operator_o <= operator_i;
            fabric_op_a_o     <= operand_a_i;
            fabric_op_b_o     <= operand_b_i;
            delay_r           <= delay_i;
            count_r           <= (delay_i == 4'd0) ? TIMEOUT_CNT : {4'd0, delay_i};
            fpga_done_o       <= 1'b0;
            fabric_start_o    <= 1'b1;
            state_r           <= RUN;
          end else begin
            state_r <= state_r;
          end
        end
        RUN: begin
          if (count_r != 8'd0) begin
            count_r <= count_r - 8'd1;
          end else begin
            count_r <= count_r;
          end
          if (capture_s) begin
            result_a_o  <= fabric_result_a_i;
            result_b_o  <= fabric_result_b_i;
            result_c_o  <= fabric_result_c_i;
            fpga_done_o <= 1'b1;
            state_r     <= DONE;
          end else if (expire_s) begin
            result_a_o  <= ERR_RESULT;
            result_b_o  <= ERR_RESULT;
            result_c_o  <= ERR_RESULT;
            fpga_done_o <= 1'b1;
            state_r     <= DONE;
          end else begin
            state_r <= RUN;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flexbex_efpga_responder.sv
// Directed bench for flexbex_efpga_responder: expected completions are queued at each
// accepted strobe and checked against the DUT when fpga_done_o rises.
module tb_flexbex_efpga_responder;

  localparam int unsigned TMO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        write_strobe_i = 1'b0;
  logic [1:0]  operator_i = 2'd0;
  logic [31:0] operand_a_i = 32'd0;
  logic [31:0] operand_b_i = 32'd0;
  logic [3:0]  delay_i = 4'd0;
  logic [31:0] result_a_o, result_b_o, result_c_o;
  logic        fpga_done_o, fabric_start_o;
  logic [1:0]  fabric_operator_o;
  logic [31:0] fabric_op_a_o, fabric_op_b_o;
  logic [31:0] fabric_result_a_i = 32'd0;
  logic [31:0] fabric_result_b_i = 32'd0;
  logic [31:0] fabric_result_c_i = 32'd0;
  logic        fabric_valid_i = 1'b0;
  logic        timeout_o, overrun_o;
  logic        clear_err_i = 1'b0;

  flexbex_efpga_responder #(.TIMEOUT(TMO), .ERR_RESULT(32'hFFFF_FFFF)) dut (
    .clk(clk), .rst_n(rst_n), .write_strobe_i(write_strobe_i), .operator_i(operator_i),
    .operand_a_i(operand_a_i), .operand_b_i(operand_b_i), .delay_i(delay_i),
    .result_a_o(result_a_o), .result_b_o(result_b_o), .result_c_o(result_c_o),
    .fpga_done_o(fpga_done_o), .fabric_start_o(fabric_start_o),
    .fabric_operator_o(fabric_operator_o), .fabric_op_a_o(fabric_op_a_o),
    .fabric_op_b_o(fabric_op_b_o), .fabric_result_a_i(fabric_result_a_i),
    .fabric_result_b_i(fabric_result_b_i), .fabric_result_c_i(fabric_result_c_i),
    .fabric_valid_i(fabric_valid_i), .timeout_o(timeout_o), .overrun_o(overrun_o),
    .clear_err_i(clear_err_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic        to;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   e0 = 0;
  logic spurious;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Accepted strobe: queue the expected completion, then drive for one edge (E0).
  task automatic strobe(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] d, input logic push, input exp_t e);
    if (push) q.push_back(e);
    operator_i = op; operand_a_i = a; operand_b_i = b; delay_i = d;
    write_strobe_i = 1'b1;
    tick();
    write_strobe_i = 1'b0;
    e0 = cyc;
  endtask

  task automatic wait_done(input string tag, input int lat);
    exp_t e;
    while (!fpga_done_o && (cyc - e0) < 40) tick();
    chk({tag, "_done"}, {31'd0, fpga_done_o}, 32'd1);
    chk({tag, "_latency"}, cyc - e0, lat);
    if (q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s_queue observed empty expected entry", tag);
    end else begin
      e = q.pop_front();
      chk({tag, "_res_a"}, result_a_o, e.a);
      chk({tag, "_res_b"}, result_b_o, e.b);
      chk({tag, "_res_c"}, result_c_o, e.c);
      chk({tag, "_timeout"}, {31'd0, timeout_o}, {31'd0, e.to});
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_res_a"}, result_a_o, 32'd0);
    chk({tag, "_res_b"}, result_b_o, 32'd0);
    chk({tag, "_res_c"}, result_c_o, 32'd0);
    chk({tag, "_op_a"}, fabric_op_a_o, 32'd0);
    chk({tag, "_op_b"}, fabric_op_b_o, 32'd0);
    chk({tag, "_flags"}, {26'd0, fpga_done_o, fabric_start_o, fabric_operator_o, timeout_o, overrun_o}, 32'd0);
  endtask

  initial begin
    exp_t e;
    #2;
    chk_all_zero("reset");
    tick();
    rst_n = 1'b1;
    tick();

    // Fixed latency 3; fabric_valid_i held high must be ignored.
    fabric_result_a_i = 32'h30; fabric_result_b_i = 32'h1; fabric_result_c_i = 32'h2;
    fabric_valid_i = 1'b1;
    e = '{a: 32'h30, b: 32'h1, c: 32'h2, to: 1'b0};
    strobe(2'd2, 32'h10, 32'h20, 4'd3, 1'b1, e);
    chk("fix_start1", {31'd0, fabric_start_o}, 32'd1);
    chk("fix_op", {30'd0, fabric_operator_o}, 32'd2);
    chk("fix_op_a", fabric_op_a_o, 32'h10);
    chk("fix_op_b", fabric_op_b_o, 32'h20);
    tick();
    chk("fix_start2", {31'd0, fabric_start_o}, 32'd0);
    wait_done("fix", 3);
    fabric_valid_i = 1'b0;
    fabric_result_a_i = 32'h55;
    tick(); tick();
    chk("fix_hold_a", result_a_o, 32'h30);
    chk("fix_hold_done", {31'd0, fpga_done_o}, 32'd1);

    // Minimum fixed latency.
    fabric_result_a_i = 32'hA1; fabric_result_b_i = 32'hB1; fabric_result_c_i = 32'hC1;
    e = '{a: 32'hA1, b: 32'hB1, c: 32'hC1, to: 1'b0};
    strobe(2'd1, 32'h1, 32'h2, 4'd1, 1'b1, e);
    chk("d1_notdone", {31'd0, fpga_done_o}, 32'd0);
    wait_done("d1", 1);

    // Handshake: valid sampled at E0+5.
    e = '{a: 32'hDEADBEEF, b: 32'h12, c: 32'h34, to: 1'b0};
    strobe(2'd3, 32'h5, 32'h6, 4'd0, 1'b1, e);
    repeat (4) tick();
    chk("hs_early", {31'd0, fpga_done_o}, 32'd0);
    fabric_result_a_i = 32'hDEADBEEF; fabric_result_b_i = 32'h12; fabric_result_c_i = 32'h34;
    fabric_valid_i = 1'b1;
    tick();
    fabric_valid_i = 1'b0;
    wait_done("hs", 5);

    // Handshake timeout, then clear.
    e = '{a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, c: 32'hFFFF_FFFF, to: 1'b1};
    strobe(2'd0, 32'h7, 32'h8, 4'd0, 1'b1, e);
    wait_done("tmo", TMO);
    clear_err_i = 1'b1;
    tick();
    clear_err_i = 1'b0;
    chk("tmo_clear", {31'd0, timeout_o}, 32'd0);

    // Valid on the same edge as the timeout expiry wins.
    fabric_result_a_i = 32'h77; fabric_result_b_i = 32'h88; fabric_result_c_i = 32'h99;
    e = '{a: 32'h77, b: 32'h88, c: 32'h99, to: 1'b0};
    strobe(2'd0, 32'h9, 32'hA, 4'd0, 1'b1, e);
    repeat (TMO - 1) tick();
    fabric_valid_i = 1'b1;
    tick();
    fabric_valid_i = 1'b0;
    wait_done("tie", TMO);

    // Overrun: ignored strobe at E0+3 together with clear_err_i (set wins).
    fabric_result_a_i = 32'h66; fabric_result_b_i = 32'h67; fabric_result_c_i = 32'h68;
    e = '{a: 32'h66, b: 32'h67, c: 32'h68, to: 1'b0};
    strobe(2'd1, 32'h11, 32'h22, 4'd6, 1'b1, e);
    tick(); tick();
    operand_a_i = 32'h99; delay_i = 4'd1; write_strobe_i = 1'b1; clear_err_i = 1'b1;
    tick();
    write_strobe_i = 1'b0; clear_err_i = 1'b0;
    chk("ovr_flag", {31'd0, overrun_o}, 32'd1);
    chk("ovr_op_a", fabric_op_a_o, 32'h11);
    wait_done("ovr", 6);
    clear_err_i = 1'b1;
    tick();
    clear_err_i = 1'b0;
    chk("ovr_clear", {31'd0, overrun_o}, 32'd0);

    // Back-to-back from DONE.
    fabric_result_a_i = 32'hCAFE; fabric_result_b_i = 32'hF00D; fabric_result_c_i = 32'hBEEF;
    e = '{a: 32'hCAFE, b: 32'hF00D, c: 32'hBEEF, to: 1'b0};
    strobe(2'd2, 32'h33, 32'h44, 4'd2, 1'b1, e);
    chk("b2b_done_drop", {31'd0, fpga_done_o}, 32'd0);
    chk("b2b_start", {31'd0, fabric_start_o}, 32'd1);
    chk("b2b_keep_res", result_a_o, 32'h66);
    wait_done("b2b", 2);

    // Asynchronous reset mid-RUN: no completion for the aborted request.
    e = '{a: 32'h0, b: 32'h0, c: 32'h0, to: 1'b0};
    strobe(2'd3, 32'hAB, 32'hCD, 4'd10, 1'b0, e);
    tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("arst");
    #3 rst_n = 1'b1;
    spurious = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      spurious = spurious | fpga_done_o;
    end
    chk("arst_spurious", {31'd0, spurious}, 32'd0);
    fabric_result_a_i = 32'h1234; fabric_result_b_i = 32'h5678; fabric_result_c_i = 32'h9ABC;
    e = '{a: 32'h1234, b: 32'h5678, c: 32'h9ABC, to: 1'b0};
    strobe(2'd1, 32'h1, 32'h1, 4'd4, 1'b1, e);
    wait_done("post_rst", 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
